// File: rtl/nibble_serial_adder_ctrl.sv
// nibble_serial_adder_ctrl: W-bit add done one nibble per cycle through a single 4-bit ripple slice.
// Build option: define NIBBLE_ADDER_OVF_EN to add the signed-overflow output ovf.

// 4-bit gate-level ripple-carry slice shared by the sequencer.
// Latency: combinational.
// Backpressure: none; pure function of its inputs.
module nibble_rca4 (
   input  logic [3:0] a,
   input  logic [3:0] b,
   input  logic       ci,
   output logic [3:0] s,
   output logic       co
);
   logic [4:0] c;

   assign c[0] = ci;

   for (genvar i = 0; i < 4; i++) begin : g_fa
      assign s[i]   = a[i] ^ b[i] ^ c[i];
      assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
   end

   assign co = c[4];
endmodule

// Sequencer adding A+B+C_in, least-significant nibble first, with a registered inter-nibble carry.
// Latency: done pulses NIBBLES+1 cycles after the accept cycle; one op per NIBBLES+2 cycles.
// Backpressure: ready is high only in IDLE; start is ignored (not queued) otherwise.
module nibble_serial_adder_ctrl #(
   parameter int NIBBLES = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   start,
   input  logic [4*NIBBLES-1:0]   A,
   input  logic [4*NIBBLES-1:0]   B,
   input  logic                   C_in,
   output logic                   ready,
   output logic                   busy,
   output logic                   done,
   output logic [4*NIBBLES-1:0]   S,
`ifdef NIBBLE_ADDER_OVF_EN
   output logic                   C_out,
   output logic                   ovf
`else
   output logic                   C_out
`endif
);
   localparam int W  = 4 * NIBBLES;
   localparam int CW = $clog2(NIBBLES);
   localparam logic [CW-1:0] LAST = CW'(NIBBLES - 1);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t         state;
   logic [W-1:0]   a_sr;
   logic [W-1:0]   b_sr;
   logic [W-1:0]   res_sr;
   logic           carry;
   logic [CW-1:0]  cnt;
   logic [3:0]     sl_s;
   logic           sl_co;
   logic [W-1:0]   res_nxt;

   nibble_rca4 u_slice (
      .a  (a_sr[3:0]),
      .b  (b_sr[3:0]),
      .ci (carry),
      .s  (sl_s),
      .co (sl_co)
   );

   assign res_nxt = {sl_s, res_sr[W-1:4]};

`ifdef NIBBLE_ADDER_OVF_EN
   // Carry into the slice MSB is recovered from its sum bit: a^b^s.
   logic ovf_nxt;
   assign ovf_nxt = sl_co ^ (a_sr[3] ^ b_sr[3] ^ sl_s[3]);
`endif

   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= IDLE;
         ready  <= 1'b1;
         busy   <= 1'b0;
         done   <= 1'b0;
         S      <= '0;
         C_out  <= 1'b0;
         a_sr   <= '0;
         b_sr   <= '0;
         res_sr <= '0;
         carry  <= 1'b0;
         cnt    <= '0;
`ifdef NIBBLE_ADDER_OVF_EN
         ovf    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  a_sr  <= A;
                  b_sr  <= B;
                  carry <= C_in;
                  cnt   <= '0;
                  ready <= 1'b0;
                  busy  <= 1'b1;
                  state <= RUN;
               end
            end
            RUN: begin
               res_sr <= res_nxt;
               carry  <= sl_co;
               a_sr   <= {4'b0000, a_sr[W-1:4]};
               b_sr   <= {4'b0000, b_sr[W-1:4]};
               if (cnt == LAST) begin
                  // Outputs are loaded with the final slice result so they are valid with done.
                  cnt   <= '0;
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  S     <= res_nxt;
                  C_out <= sl_co;
`ifdef NIBBLE_ADDER_OVF_EN
                  ovf   <= ovf_nxt;
`endif
                  state <= DONE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            DONE: begin
               done  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
            default: begin
               done  <= 1'b0;
               busy  <= 1'b0;
               ready <= 1'b1;
               state <= IDLE;
            end
         endcase
      end
   end
endmodule
